// File: rtl/dot_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : dot_matrix_scanner
//  Description : Row-multiplexed LED dot-matrix scanner with double-buffered
//                image banks, frame-aligned bank swap, blink and blank.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock       in   1              scan clock, rising edge
//    reset       in   1              asynchronous reset, active low
//    wr_en       in   1              write strobe into the back bank
//    wr_row      in   log2(ROWS)     row index for a write
//    wr_data     in   COLS           row column bits, 1 = LED on
//    swap_req    in   1              exchange banks at the next frame boundary
//    blink_en    in   1              enable blinking of the displayed image
//    blank       in   1              force the display dark
//    dot_row     out  ROWS           row select, one-hot-low, row 0 = MSB
//    dot_col     out  COLS           column drive, active high
//    swap_ack    out  1              one-cycle pulse after a bank swap
//    frame_start out  1              high while row 0 of a frame is first shown
// ============================================================================
module dot_matrix_scanner #(
   parameter int ROWS         = 8,
   parameter int COLS         = 8,
   parameter int DWELL        = 1,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [$clog2(ROWS)-1:0] wr_row,
   input  logic [COLS-1:0]         wr_data,
   input  logic                    swap_req,
   input  logic                    blink_en,
   input  logic                    blank,
   output logic [ROWS-1:0]         dot_row,
   output logic [COLS-1:0]         dot_col,
   output logic                    swap_ack,
   output logic                    frame_start
);

   localparam int c_rw = $clog2(ROWS);
   localparam int c_dw = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int c_fw = $clog2(2 * BLINK_FRAMES);

   localparam logic [c_rw-1:0] c_row_last   = c_rw'(ROWS - 1);
   localparam logic [c_dw-1:0] c_dwell_last = c_dw'(DWELL - 1);
   localparam logic [c_fw-1:0] c_frame_last = c_fw'(2 * BLINK_FRAMES - 1);
   localparam logic [c_fw-1:0] c_blink_half = c_fw'(BLINK_FRAMES);
   localparam logic [ROWS-1:0] c_row_msb    = {1'b1, {(ROWS-1){1'b0}}};

   logic [c_dw-1:0] r_dwell;
   logic [c_rw-1:0] r_rc;
   logic [c_fw-1:0] r_frame;
   logic            r_pending;
   logic            r_bank_sel;   // 0: bank0 is front, 1: bank1 is front
   logic [COLS-1:0] r_bank0 [ROWS];
   logic [COLS-1:0] r_bank1 [ROWS];

   logic            w_dwell_end;
   logic            w_wrap;
   logic            w_swap;
   logic            w_wr_ok;
   logic            w_blink_off;
   logic [COLS-1:0] w_front_row;
   logic [ROWS-1:0] w_row_sel;

   assign w_dwell_end = (r_dwell == c_dwell_last);
   assign w_wrap      = w_dwell_end && (r_rc == c_row_last);
   // A request arriving on the wrap edge itself is honoured immediately.
   assign w_swap      = w_wrap && (r_pending || swap_req);
   assign w_wr_ok     = (32'(wr_row) < 32'(ROWS));
   assign w_blink_off = blink_en && (r_frame >= c_blink_half);
   assign w_front_row = r_bank_sel ? r_bank1[r_rc] : r_bank0[r_rc];
   // Row 0 pulls the MSB low, row ROWS-1 pulls the LSB low.
   assign w_row_sel   = ~(c_row_msb >> r_rc);

   // Scan position, frame counter, swap handshake
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_dwell    <= '0;
         r_rc       <= '0;
         r_frame    <= '0;
         r_pending  <= 1'b0;
         r_bank_sel <= 1'b0;
      end else begin
         if (w_dwell_end) begin
            r_dwell <= '0;
            r_rc    <= (r_rc == c_row_last) ? '0 : r_rc + c_rw'(1);
         end else begin
            r_dwell <= r_dwell + c_dw'(1);
         end
         if (w_wrap) begin
            r_frame <= (r_frame == c_frame_last) ? '0 : r_frame + c_fw'(1);
         end
         if (w_swap) begin
            r_pending  <= 1'b0;
            r_bank_sel <= ~r_bank_sel;
         end else if (swap_req) begin
            r_pending  <= 1'b1;
         end
      end
   end

   // Writes target the bank that is back before this edge, so a write on
   // the swap edge ends up in the new front bank.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ROWS; i++) begin
            r_bank0[i] <= '0;
            r_bank1[i] <= '0;
         end
      end else if (wr_en && w_wr_ok) begin
         if (r_bank_sel) begin
            r_bank0[wr_row] <= wr_data;
         end else begin
            r_bank1[wr_row] <= wr_data;
         end
      end
   end

   // Registered outputs, one clock behind the scan position
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dot_row     <= '1;
         dot_col     <= '0;
         swap_ack    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         dot_row     <= blank ? '1 : w_row_sel;
         dot_col     <= (blank || w_blink_off) ? '0 : w_front_row;
         swap_ack    <= w_swap;
         frame_start <= (r_rc == '0) && (r_dwell == '0);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dot_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dot_matrix_scanner
//  Description : Self-checking bench for dot_matrix_scanner. Two instances
//                (DWELL=1 and DWELL=4) share stimulus; a reference model
//                predicts each registered output word into a queue that is
//                popped and compared after every clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_matrix_scanner;

   logic       clock;
   logic       reset;
   logic       wr_en;
   logic [2:0] wr_row;
   logic [7:0] wr_data;
   logic       swap_req;
   logic       blink_en;
   logic       blank;

   logic [7:0] w_row [2];
   logic [7:0] w_col [2];
   logic       w_ack [2];
   logic       w_fs  [2];

   dot_matrix_scanner #(.ROWS(8), .COLS(8), .DWELL(1), .BLINK_FRAMES(2)) u_dut1 (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_row(wr_row),
      .wr_data(wr_data), .swap_req(swap_req), .blink_en(blink_en),
      .blank(blank), .dot_row(w_row[0]), .dot_col(w_col[0]),
      .swap_ack(w_ack[0]), .frame_start(w_fs[0])
   );

   dot_matrix_scanner #(.ROWS(8), .COLS(8), .DWELL(4), .BLINK_FRAMES(2)) u_dut4 (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_row(wr_row),
      .wr_data(wr_data), .swap_req(swap_req), .blink_en(blink_en),
      .blank(blank), .dot_row(w_row[1]), .dot_col(w_col[1]),
      .swap_ack(w_ack[1]), .frame_start(w_fs[1])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state per instance: [inst]
   int         m_rc    [2];
   int         m_dwell [2];
   int         m_frame [2];
   bit         m_pend  [2];
   bit         m_sel   [2];
   logic [7:0] m_bank  [2][2][8];
   int         c_dwell [2] = '{1, 4};

   // Scoreboard word: {dot_row, dot_col, swap_ack, frame_start}
   logic [17:0] q_exp [2][$];

   logic [7:0] c_pat [8] = '{8'h3C, 8'h42, 8'h81, 8'hBD, 8'hBD, 8'h81, 8'h42, 8'h3C};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_rc[d] = 0; m_dwell[d] = 0; m_frame[d] = 0;
         m_pend[d] = 1'b0; m_sel[d] = 1'b0;
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++) m_bank[d][b][r] = 8'h00;
         q_exp[d].delete();
      end
   endtask

   // Predict what instance d registers at the coming edge, then advance it.
   task automatic model_step(input int d);
      logic [7:0] e_row, e_col;
      bit         e_fs, wrap, swp;
      e_row = blank ? 8'hFF : ~(8'h80 >> m_rc[d]);
      e_col = (blank || (blink_en && m_frame[d] >= 2)) ? 8'h00 : m_bank[d][m_sel[d]][m_rc[d]];
      e_fs  = (m_rc[d] == 0) && (m_dwell[d] == 0);
      wrap  = (m_dwell[d] == c_dwell[d] - 1) && (m_rc[d] == 7);
      swp   = wrap && (m_pend[d] || swap_req);
      q_exp[d].push_back({e_row, e_col, swp, e_fs});
      if (wr_en) m_bank[d][!m_sel[d]][wr_row] = wr_data;
      if (swp) begin
         m_pend[d] = 1'b0;
         m_sel[d]  = !m_sel[d];
      end else if (swap_req) begin
         m_pend[d] = 1'b1;
      end
      if (wrap) m_frame[d] = (m_frame[d] + 1) % 4;
      if (m_dwell[d] == c_dwell[d] - 1) begin
         m_dwell[d] = 0;
         m_rc[d]    = (m_rc[d] + 1) % 8;
      end else begin
         m_dwell[d] = m_dwell[d] + 1;
      end
   endtask

   // One clock: push predictions, clock, then pop and compare both instances.
   task automatic tick();
      logic [17:0] e;
      model_step(0);
      model_step(1);
      @(posedge clock);
      #1;
      for (int d = 0; d < 2; d++) begin
         if (q_exp[d].size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            e = q_exp[d].pop_front();
            chk(d == 0 ? "dwell1_out" : "dwell4_out",
                {14'd0, w_row[d], w_col[d], w_ack[d], w_fs[d]}, {14'd0, e});
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk({tag, "_row"}, {24'd0, w_row[d]}, 32'h0000_00FF);
         chk({tag, "_col"}, {24'd0, w_col[d]}, 32'h0);
         chk({tag, "_ack"}, {31'd0, w_ack[d]}, 32'h0);
         chk({tag, "_fs"},  {31'd0, w_fs[d]},  32'h0);
      end
   endtask

   int acks;
   bit got_ack;

   initial begin
      reset = 1'b0; wr_en = 1'b0; wr_row = '0; wr_data = '0;
      swap_req = 1'b0; blink_en = 1'b0; blank = 1'b0;
      model_reset();
      #23;
      check_reset_outputs("reset_state");
      @(posedge clock); #1;
      reset = 1'b1;

      // Free-running scan with empty banks
      tick();
      chk("first_row0", {24'd0, w_row[0]}, 32'h7F);
      chk("first_fs",   {31'd0, w_fs[0]},  32'h1);
      tick();
      chk("second_row", {24'd0, w_row[0]}, 32'hBF);
      for (int i = 0; i < 15; i++) tick();

      // Load the back bank, then request a swap mid-frame
      for (int r = 0; r < 8; r++) begin
         wr_en = 1'b1; wr_row = 3'(r); wr_data = c_pat[r];
         tick();
      end
      wr_en = 1'b0;
      while (m_rc[0] != 3) tick();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      got_ack = 1'b0;
      acks = 0;
      for (int i = 0; i < 24 && !got_ack; i++) begin
         tick();
         if (w_ack[0]) begin
            got_ack = 1'b1;
            acks++;
            chk("old_frame_row7_col", {24'd0, w_col[0]}, 32'h0);
         end
      end
      chk("swap_ack_seen", {31'd0, got_ack}, 32'h1);
      for (int r = 0; r < 8; r++) begin
         tick();
         if (w_ack[0]) acks++;
         chk("pattern_col", {24'd0, w_col[0]}, {24'd0, c_pat[r]});
      end
      chk("single_swap_ack", acks, 1);

      // Held request: one swap per wrap edge while held
      swap_req = 1'b1;
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (w_ack[0]) acks++;
      end
      swap_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (w_ack[0]) acks++;
      end
      chk("held_req_swaps", acks, 3);

      // Make sure the patterned bank is in front before blinking
      if (m_bank[0][m_sel[0]][0] != 8'h3C) begin
         swap_req = 1'b1; tick(); swap_req = 1'b0;
      end
      for (int i = 0; i < 10; i++) tick();

      // Blink over five frames
      blink_en = 1'b1;
      for (int i = 0; i < 40; i++) tick();
      blink_en = 1'b0;

      // Blank toggled in the middle of a DWELL=4 row
      while (m_dwell[1] != 2) tick();
      blank = 1'b1;
      tick();
      chk("blank_row", {24'd0, w_row[1]}, 32'hFF);
      chk("blank_col", {24'd0, w_col[1]}, 32'h00);
      for (int i = 0; i < 5; i++) tick();
      blank = 1'b0;
      for (int i = 0; i < 40; i++) tick();

      // Reset in row 5 with a swap pending
      while (m_rc[0] != 2) tick();
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      while (m_rc[0] != 5) tick();
      chk("pending_before_reset", {31'd0, m_pend[0]}, 32'h1);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      tick();
      chk("post_reset_row", {24'd0, w_row[0]}, 32'h7F);
      chk("post_reset_col", {24'd0, w_col[0]}, 32'h00);
      chk("post_reset_fs",  {31'd0, w_fs[0]},  32'h1);
      chk("post_reset_ack", {31'd0, w_ack[0]}, 32'h0);
      acks = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (w_ack[0]) acks++;
      end
      chk("post_reset_no_swap", acks, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
